// File: rtl/sram_like_ram_slave.sv
// sram_like_ram_slave: word-organised RAM answering the SRAM-like handshake after a fixed latency
module sram_like_ram_slave #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [3:0]  i_select,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_stall,
    output logic        o_addr_ok,
    output logic        o_data_ok,
    output logic [31:0] o_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt;
    logic                   r_wr;
    logic [3:0]             r_sel;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_data_ok;
    logic [31:0]            r_mem [0:(1<<ADDR_BITS)-1];

    logic                   w_accept;
    logic [ADDR_BITS-1:0]   w_rd_idx;
    logic                   w_rd;
    logic                   w_fwd;
    logic [31:0]            w_mem_word;
    logic [31:0]            w_rd_word;
    logic                   w_unused_addr;

    assign o_addr_ok     = i_req & ~i_stall & ~i_rst & (r_state == IDLE || r_state == RESP);
    assign w_accept      = i_req & o_addr_ok;
    assign o_data_ok     = r_data_ok;
    assign o_rdata       = r_rdata;
    assign w_unused_addr = &{1'b0, i_addr[31:ADDR_BITS+2], i_addr[1:0]};

    // Next state: acceptance wins, BUSY counts down to RESP, RESP falls back to IDLE
    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (LATENCY == 1) ? RESP : BUSY;
        else if (r_state == BUSY)
            w_next = (r_cnt == 4'd1) ? RESP : BUSY;
        else if (r_state == RESP)
            w_next = IDLE;
    end

    // Read word for the response about to be entered; a write committing this
    // cycle to the same word is merged in so back-to-back read-after-write sees it
    always_comb begin
        w_rd_idx   = w_accept ? i_addr[ADDR_BITS+1:2] : r_idx;
        w_rd       = w_accept ? ~i_wr : ~r_wr;
        w_mem_word = r_mem[w_rd_idx];
        w_fwd      = (r_state == RESP) && r_wr && (r_idx == w_rd_idx);
        w_rd_word  = w_mem_word;
        for (int b = 0; b < 4; b++)
            w_rd_word[8*b +: 8] = (w_fwd && r_sel[b]) ? r_wdata[8*b +: 8] : w_mem_word[8*b +: 8];
    end

    // State, counter, latched request and registered response outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_sel     <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_data_ok <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_accept ? 4'(LATENCY - 1) : (r_state == BUSY) ? r_cnt - 4'd1 : r_cnt;
            r_data_ok <= (w_next == RESP);
            if (w_accept) begin
                r_wr    <= i_wr;
                r_sel   <= i_select;
                r_idx   <= i_addr[ADDR_BITS+1:2];
                r_wdata <= i_wdata;
            end
            if (w_next == RESP && w_rd)
                r_rdata <= w_rd_word;
        end
    end

    // Byte-enabled write commit at the end of the write's RESP cycle; array is never reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == RESP && r_wr)
            for (int b = 0; b < 4; b++)
                if (r_sel[b])
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_sram_like_ram_slave.sv
// tb_sram_like_ram_slave: scoreboard bench for the SRAM-like RAM slave at latencies 2, 1 and 15
module tb_sram_like_ram_slave;
    typedef struct {
        int          due;
        logic        wr;
        logic [9:0]  idx;
        logic [31:0] d;
        logic [3:0]  sel;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, wr = 1'b0, stall = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    logic        req15 = 1'b0, wr15 = 1'b0;
    logic [31:0] addr15 = 32'h0, wdata15 = 32'h0;
    logic        addr_ok15, data_ok15;
    logic [31:0] rdata15;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    ent_t        q[$];
    logic [31:0] m [0:1023];
    logic        prev_dok = 1'b0;

    sram_like_ram_slave #(.ADDR_BITS(10), .LATENCY(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_select(sel), .i_addr(addr),
        .i_wdata(wdata), .i_stall(stall), .o_addr_ok(addr_ok), .o_data_ok(data_ok), .o_rdata(rdata));

    sram_like_ram_slave #(.ADDR_BITS(10), .LATENCY(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_wr(wr1), .i_select(4'hF), .i_addr(addr1),
        .i_wdata(wdata1), .i_stall(1'b0), .o_addr_ok(addr_ok1), .o_data_ok(data_ok1), .o_rdata(rdata1));

    sram_like_ram_slave #(.ADDR_BITS(10), .LATENCY(15)) u15 (
        .i_clk(clk), .i_rst(rst), .i_req(req15), .i_wr(wr15), .i_select(4'hF), .i_addr(addr15),
        .i_wdata(wdata15), .i_stall(1'b0), .o_addr_ok(addr_ok15), .o_data_ok(data_ok15), .o_rdata(rdata15));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard for the LATENCY=2 instance: completions retire first so a
    // read accepted in a write's response cycle sees the updated model
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (data_ok) begin
                chk("double data_ok", 32'(prev_dok), 32'd0);
                chk("data_ok with nothing pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("data_ok cycle", 32'(cyc), 32'(e.due));
                    if (e.wr) begin
                        for (int b = 0; b < 4; b++)
                            if (e.sel[b]) m[e.idx][8*b +: 8] = e.d[8*b +: 8];
                    end else begin
                        chk("rdata", rdata, e.d);
                    end
                end
            end
            if (req && addr_ok) begin
                e.due = cyc + 2;
                e.wr  = wr;
                e.idx = addr[11:2];
                e.sel = sel;
                e.d   = wr ? wdata : m[addr[11:2]];
                q.push_back(e);
            end
        end
        prev_dok = data_ok;
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        req = 1'b1; wr = w; addr = a; wdata = d; sel = s;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!addr_ok && k < 20);
        chk("accept", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        req = 1'b1; req1 = 1'b1; req15 = 1'b1;
        @(negedge clk);
        chk("addr_ok in reset", 32'(addr_ok), 32'd0);
        chk("addr_ok1 in reset", 32'(addr_ok1), 32'd0);
        chk("addr_ok15 in reset", 32'(addr_ok15), 32'd0);
        req = 1'b0; req1 = 1'b0; req15 = 1'b0;
        @(negedge clk);
        chk("data_ok reset", 32'(data_ok), 32'd0);
        chk("rdata reset", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        drain();
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        drain();
        chk("read 0x100", rdata, 32'hDEADBEEF);

        issue(1'b1, 32'h40, 32'h11223344, 4'hF);
        drain();
        issue(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101);
        drain();
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        drain();
        chk("byte enables", rdata, 32'h11BB33DD);
        issue(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0);
        drain();
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        drain();
        chk("select 0 write", rdata, 32'h11BB33DD);

        req = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'h55; sel = 4'hF;
        @(negedge clk);
        chk("b2b write accept", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        chk("addr_ok in BUSY", 32'(addr_ok), 32'd0);
        @(negedge clk);
        chk("b2b read accept in RESP", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("addr_ok in read BUSY", 32'(addr_ok), 32'd0);
        drain();
        chk("read after write", rdata, 32'h55);

        stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("addr_ok under stall", 32'(addr_ok), 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        chk("accept after stall", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        drain();
        issue(1'b1, 32'h20, 32'h12345678, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("data_ok after mid-op reset", 32'(data_ok), 32'd0);
        chk("rdata after mid-op reset", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no stale data_ok", 32'(data_ok), 32'd0);
        end
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        drain();
        chk("dropped write", rdata, 32'hCAFEF00D);
        issue(1'b0, 32'h1000_0100, 32'h0, 4'h0);
        drain();
        chk("aliased read L2", rdata, 32'hDEADBEEF);

        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h100; wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        chk("L1 write accept", 32'(addr_ok1), 32'd1);
        chk("L1 data_ok at T", 32'(data_ok1), 32'd0);
        @(posedge clk); #1;
        wr1 = 1'b0; addr1 = 32'h1000_0100;
        @(negedge clk);
        chk("L1 write data_ok T+1", 32'(data_ok1), 32'd1);
        chk("L1 read accept in RESP", 32'(addr_ok1), 32'd1);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        chk("L1 read data_ok T+1", 32'(data_ok1), 32'd1);
        chk("L1 aliased rdata", rdata1, 32'hDEADBEEF);
        @(negedge clk);
        chk("L1 single pulse", 32'(data_ok1), 32'd0);

        @(posedge clk); #1;
        req15 = 1'b1; wr15 = 1'b1; addr15 = 32'h100; wdata15 = 32'hDEADBEEF;
        @(negedge clk);
        chk("L15 write accept", 32'(addr_ok15), 32'd1);
        @(posedge clk); #1;
        req15 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        req15 = 1'b1; wr15 = 1'b0; addr15 = 32'h1000_0100;
        @(negedge clk);
        chk("L15 read accept", 32'(addr_ok15), 32'd1);
        @(posedge clk); #1;
        req15 = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            chk("L15 early data_ok", 32'(data_ok15), 32'd0);
        end
        @(negedge clk);
        chk("L15 data_ok T+15", 32'(data_ok15), 32'd1);
        chk("L15 aliased rdata", rdata15, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        chk("scoreboard empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
